// File: rtl/rgmii_rx_assembler.sv
// RGMII receive assembler: rebuilds a GMII byte stream from IDDR-split RX data
// (DDR merge at 1000M, SFD-aligned nibble pairing at 10/100M) and decodes in-band status.
module rgmii_rx_assembler #(
  parameter int unsigned STATUS_FILTER = 2
) (
  input  logic       rxclk,
  input  logic       reset_n,
  input  logic       speed,
  input  logic [3:0] rgmii_rxd_r,
  input  logic [3:0] rgmii_rxd_f,
  input  logic       rgmii_ctl_r,
  input  logic       rgmii_ctl_f,
  output logic [7:0] rxd,
  output logic       rxdv,
  output logic       rxer,
  output logic       rxce,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex,
  output logic       nibble_err
);

  localparam logic [0:0] ST_LO      = 1'b0;
  localparam logic [0:0] ST_HI      = 1'b1;
  localparam logic [3:0] FILTER_CNT = 4'(STATUS_FILTER);
  localparam logic [3:0] CNT_MAX    = 4'hF;

  logic       w_dv;
  logic       w_er;
  logic       w_mode_nx;
  logic [7:0] w_pair;
  logic       w_realign;
  logic [0:0] w_state_nx;
  logic       w_sfd_nx;
  logic       w_hunt_nx;
  logic [3:0] w_nib_nx;
  logic       w_nib_er_nx;
  logic [7:0] w_rxd_nx;
  logic       w_rxdv_nx;
  logic       w_rxer_nx;
  logic       w_rxce_nx;
  logic       w_nerr_nx;
  logic       w_cand;
  logic [3:0] w_cand_nx;
  logic [3:0] w_cnt_nx;
  logic       w_stat_upd;

  logic       r_mode;
  logic [0:0] r_state;
  logic       r_sfd_seen;
  logic       r_hunt;
  logic [3:0] r_nib;
  logic       r_nib_er;
  logic [3:0] r_prev_nib;
  logic       r_prev_er;
  logic [3:0] r_cnt;
  logic [3:0] r_cand;
  logic [7:0] r_rxd;
  logic       r_rxdv;
  logic       r_rxer;
  logic       r_rxce;
  logic       r_nerr;
  logic       r_link_up;
  logic [1:0] r_link_speed;
  logic       r_full_duplex;

  assign w_dv      = rgmii_ctl_r;
  assign w_er      = rgmii_ctl_r ^ rgmii_ctl_f;
  assign w_mode_nx = w_dv ? r_mode : speed;
  assign w_pair    = {rgmii_rxd_r, r_nib};
  assign w_realign = ~r_sfd_seen & (rgmii_rxd_r == 4'hD) & (r_prev_nib == 4'h5);

  // Byte assembly and alignment; r_hunt suppresses bytes of a frame entered mid-way after reset
  always_comb begin
    w_state_nx  = r_state;
    w_sfd_nx    = r_sfd_seen;
    w_hunt_nx   = r_hunt;
    w_nib_nx    = r_nib;
    w_nib_er_nx = r_nib_er;
    w_rxd_nx    = 8'h00;
    w_rxdv_nx   = 1'b0;
    w_rxer_nx   = 1'b0;
    w_rxce_nx   = 1'b0;
    w_nerr_nx   = 1'b0;
    if (!w_dv) begin
      w_state_nx = ST_LO;
      w_sfd_nx   = 1'b0;
      w_hunt_nx  = 1'b0;
      w_rxce_nx  = 1'b1;
      w_rxer_nx  = w_er;
      w_nerr_nx  = (r_state == ST_HI) & ~r_mode & ~r_hunt;
      if (r_mode) begin
        w_rxd_nx = {rgmii_rxd_f, rgmii_rxd_r};
      end else begin
        w_rxd_nx = {rgmii_rxd_r, rgmii_rxd_r};
      end
    end else if (r_mode) begin
      w_rxd_nx  = {rgmii_rxd_f, rgmii_rxd_r};
      w_rxdv_nx = 1'b1;
      w_rxer_nx = w_er;
      w_rxce_nx = 1'b1;
    end else begin
      case (r_state)
        ST_LO: begin
          if (w_realign) begin
            w_rxd_nx  = 8'hD5;
            w_rxdv_nx = 1'b1;
            w_rxer_nx = w_er | r_prev_er;
            w_rxce_nx = 1'b1;
            w_sfd_nx  = 1'b1;
            w_hunt_nx = 1'b0;
          end else begin
            w_nib_nx    = rgmii_rxd_r;
            w_nib_er_nx = w_er;
            w_state_nx  = ST_HI;
          end
        end
        ST_HI: begin
          w_rxd_nx   = w_pair;
          w_rxdv_nx  = 1'b1;
          w_rxer_nx  = r_nib_er | w_er;
          w_state_nx = ST_LO;
          if (w_pair == 8'hD5) begin
            w_sfd_nx  = 1'b1;
            w_hunt_nx = 1'b0;
            w_rxce_nx = 1'b1;
          end else begin
            w_rxce_nx = ~r_hunt;
          end
        end
        default: begin
          w_state_nx = ST_LO;
        end
      endcase
    end
  end

  // In-band status filter: count consecutive identical idle status samples
  always_comb begin
    w_cand = ~w_dv & ~w_er & (rgmii_rxd_r == rgmii_rxd_f);
    if (w_cand) begin
      w_cand_nx = rgmii_rxd_r;
      if ((rgmii_rxd_r == r_cand) && (r_cnt != 4'd0)) begin
        w_cnt_nx = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + 4'd1);
      end else begin
        w_cnt_nx = 4'd1;
      end
    end else begin
      w_cand_nx = r_cand;
      w_cnt_nx  = 4'd0;
    end
    w_stat_upd = w_cand & (w_cnt_nx == FILTER_CNT);
  end

  // State and output registers
  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode        <= 1'b0;
      r_state       <= ST_LO;
      r_sfd_seen    <= 1'b0;
      r_hunt        <= 1'b1;
      r_nib         <= 4'h0;
      r_nib_er      <= 1'b0;
      r_prev_nib    <= 4'h0;
      r_prev_er     <= 1'b0;
      r_cnt         <= 4'd0;
      r_cand        <= 4'h0;
      r_rxd         <= 8'h00;
      r_rxdv        <= 1'b0;
      r_rxer        <= 1'b0;
      r_rxce        <= 1'b0;
      r_nerr        <= 1'b0;
      r_link_up     <= 1'b0;
      r_link_speed  <= 2'b00;
      r_full_duplex <= 1'b0;
    end else begin
      r_mode     <= w_mode_nx;
      r_state    <= w_state_nx;
      r_sfd_seen <= w_sfd_nx;
      r_hunt     <= w_hunt_nx;
      r_nib      <= w_nib_nx;
      r_nib_er   <= w_nib_er_nx;
      r_prev_nib <= rgmii_rxd_r;
      r_prev_er  <= w_er;
      r_cnt      <= w_cnt_nx;
      r_cand     <= w_cand_nx;
      r_rxd      <= w_rxd_nx;
      r_rxdv     <= w_rxdv_nx;
      r_rxer     <= w_rxer_nx;
      r_rxce     <= w_rxce_nx;
      r_nerr     <= w_nerr_nx;
      if (w_stat_upd) begin
        r_link_up     <= rgmii_rxd_r[0];
        r_link_speed  <= rgmii_rxd_r[2:1];
        r_full_duplex <= rgmii_rxd_r[3];
      end else begin
        r_link_up     <= r_link_up;
        r_link_speed  <= r_link_speed;
        r_full_duplex <= r_full_duplex;
      end
    end
  end

  assign rxd         = r_rxd;
  assign rxdv        = r_rxdv;
  assign rxer        = r_rxer;
  assign rxce        = r_rxce;
  assign nibble_err  = r_nerr;
  assign link_up     = r_link_up;
  assign link_speed  = r_link_speed;
  assign full_duplex = r_full_duplex;

endmodule

// File: tb/tb_rgmii_rx_assembler.sv
// Scoreboard bench for rgmii_rx_assembler: frame-level reference model feeds an
// expected-output queue, an independent monitor pops and compares on every strobe.
module tb_rgmii_rx_assembler;

  localparam int FILT = 2;

  logic       rxclk       = 1'b0;
  logic       reset_n     = 1'b0;
  logic       speed       = 1'b0;
  logic [3:0] rgmii_rxd_r = 4'h0;
  logic [3:0] rgmii_rxd_f = 4'h0;
  logic       rgmii_ctl_r = 1'b0;
  logic       rgmii_ctl_f = 1'b0;
  logic [7:0] rxd;
  logic       rxdv;
  logic       rxer;
  logic       rxce;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;
  logic       nibble_err;

  always #5 rxclk = ~rxclk;

  rgmii_rx_assembler #(.STATUS_FILTER(FILT)) dut (
    .rxclk(rxclk), .reset_n(reset_n), .speed(speed),
    .rgmii_rxd_r(rgmii_rxd_r), .rgmii_rxd_f(rgmii_rxd_f),
    .rgmii_ctl_r(rgmii_ctl_r), .rgmii_ctl_f(rgmii_ctl_f),
    .rxd(rxd), .rxdv(rxdv), .rxer(rxer), .rxce(rxce),
    .link_up(link_up), .link_speed(link_speed), .full_duplex(full_duplex),
    .nibble_err(nibble_err)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       dv;
    logic       er;
    logic       ne;
    logic       up;
    logic [1:0] spd;
    logic       fd;
  } exp_t;

  exp_t expq[$];
  int   errors    = 0;
  int   checks    = 0;
  bit   drain_req = 1'b0;
  int   drain_cyc = 0;

  // reference model state
  logic       m_mode = 1'b0;
  logic [3:0] m_pn   = 4'h0;
  logic       m_pe   = 1'b0;
  bit         m_hunt = 1'b0;
  bit         m_odd  = 1'b0;
  logic [3:0] m_stat = 4'h0;
  int         hist[$];
  logic [3:0] fr_n[$];
  logic [3:0] fr_f[$];
  bit         fr_e[$];

  function automatic exp_t mk(input logic [7:0] d, input logic dv, input logic er, input logic ne);
    exp_t x;
    x.d   = d;
    x.dv  = dv;
    x.er  = er;
    x.ne  = ne;
    x.up  = m_stat[0];
    x.spd = m_stat[2:1];
    x.fd  = m_stat[3];
    return x;
  endfunction

  task automatic tick();
    @(posedge rxclk);
    #2;
  endtask

  // status is adopted once the last FILT samples are all the same idle status code
  task automatic note_status(input int c);
    bit same;
    hist.push_back(c);
    if (hist.size() > FILT) void'(hist.pop_front());
    if (hist.size() == FILT) begin
      same = 1'b1;
      for (int i = 0; i < FILT; i++) if (hist[i] < 0 || hist[i] != hist[0]) same = 1'b0;
      if (same) m_stat = 4'(hist[0]);
    end
  endtask

  task automatic idle(input logic [3:0] r, input logic [3:0] f, input logic er, input logic sp);
    tick();
    rgmii_rxd_r = r; rgmii_rxd_f = f; rgmii_ctl_r = 1'b0; rgmii_ctl_f = er; speed = sp;
    reset_n = 1'b1;
    note_status((!er && r == f) ? int'(r) : -1);
    expq.push_back(mk(m_mode ? {f, r} : {r, r}, 1'b0, er, m_odd));
    m_odd = 1'b0; m_hunt = 1'b0; m_mode = sp; m_pn = r; m_pe = er;
  endtask

  task automatic clear_fr();
    fr_n.delete(); fr_f.delete(); fr_e.delete();
  endtask

  task automatic add_nib(input logic [3:0] n, input logic [3:0] f, input bit e);
    fr_n.push_back(n); fr_f.push_back(f); fr_e.push_back(e);
  endtask

  // 10/100 frame: pair nibbles low-first; an unaligned 5,D before the SFD restarts pairing
  task automatic model100();
    int k; int i; bit sfd; bit hunt; logic [3:0] ln; logic le; logic [7:0] b;
    k = fr_n.size(); i = 0; sfd = 1'b0; hunt = m_hunt;
    while (i < k) begin
      ln = (i == 0) ? m_pn : fr_n[i-1];
      le = (i == 0) ? m_pe : fr_e[i-1];
      if (!sfd && fr_n[i] == 4'hD && ln == 4'h5) begin
        expq.push_back(mk(8'hD5, 1'b1, fr_e[i] | le, 1'b0));
        sfd = 1'b1; hunt = 1'b0; i = i + 1;
      end else if (i + 1 < k) begin
        b = {fr_n[i+1], fr_n[i]};
        if (b == 8'hD5) begin sfd = 1'b1; hunt = 1'b0; end
        if (!hunt) expq.push_back(mk(b, 1'b1, fr_e[i] | fr_e[i+1], 1'b0));
        i = i + 2;
      end else begin
        m_odd = !hunt;
        i = i + 1;
      end
    end
    m_hunt = hunt;
  endtask

  task automatic frame();
    if (m_mode) begin
      for (int i = 0; i < fr_n.size(); i++) expq.push_back(mk({fr_f[i], fr_n[i]}, 1'b1, fr_e[i], 1'b0));
    end else begin
      model100();
    end
    for (int i = 0; i < fr_n.size(); i++) begin
      tick();
      rgmii_rxd_r = fr_n[i]; rgmii_rxd_f = fr_f[i];
      rgmii_ctl_r = 1'b1; rgmii_ctl_f = ~fr_e[i];
      speed = 1'($urandom);
      reset_n = 1'b1;
      note_status(-1);
      m_pn = fr_n[i]; m_pe = fr_e[i];
    end
  endtask

  task automatic nibs100(input logic [35:0] v, input int cnt);
    clear_fr();
    for (int i = cnt - 1; i >= 0; i--) add_nib(v[i*4 +: 4], 4'($urandom), 1'b0);
    frame();
  endtask

  // monitor: compares every strobe against the scoreboard, checks reset values while reset is low
  always @(negedge rxclk) begin
    exp_t got;
    exp_t e;
    got = {rxd, rxdv, rxer, nibble_err, link_up, link_speed, full_duplex};
    if (!reset_n) begin
      checks++;
      if (got !== 15'h0 || rxce !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: got rxd=%02h dv=%0b er=%0b ce=%0b nerr=%0b up=%0b spd=%0b fd=%0b, required all zero",
                 rxd, rxdv, rxer, rxce, nibble_err, link_up, link_speed, full_duplex);
      end
    end else if (rxce === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got rxd=%02h dv=%0b er=%0b, required no strobe", rxd, rxdv, rxer);
      end else begin
        e = expq.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL output: got rxd=%02h dv=%0b er=%0b nerr=%0b up=%0b spd=%0b fd=%0b, required rxd=%02h dv=%0b er=%0b nerr=%0b up=%0b spd=%0b fd=%0b @%0t",
                   rxd, rxdv, rxer, nibble_err, link_up, link_speed, full_duplex,
                   e.d, e.dv, e.er, e.ne, e.up, e.spd, e.fd, $time);
        end
      end
    end else begin
      checks++;
      if (nibble_err !== 1'b0) begin
        errors++;
        $display("FAIL nerr_without_strobe: got nibble_err=%0b, required 0", nibble_err);
      end
    end
    if (drain_req) begin
      drain_cyc++;
      if (expq.size() == 0) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end else if (drain_cyc > 50) begin
        checks++;
        errors++;
        $display("FAIL drain: got %0d outputs still pending, required 0", expq.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] r;
    logic [3:0] f;
    bit         tsp;
    int         len;
    reset_n = 1'b0;
    repeat (3) tick();

    // 1000M: seven 0x55 then 0xD5
    idle(4'h0, 4'h0, 1'b0, 1'b1);
    idle(4'h0, 4'h0, 1'b0, 1'b1);
    clear_fr();
    for (int i = 0; i < 7; i++) add_nib(4'h5, 4'h5, 1'b0);
    add_nib(4'h5, 4'hD, 1'b0);
    frame();
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    idle(4'h0, 4'h0, 1'b0, 1'b0);

    // 10/100 aligned, misaligned, realigned, odd end
    nibs100(36'h0000_5555_5D12, 8);
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    nibs100(36'h0000_0555_DAB0 >> 4, 6);
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    nibs100(36'h0000_5555_DC3 , 7);
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    nibs100(36'h5_5555_D347, 9);
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    idle(4'h0, 4'h0, 1'b1, 1'b0);

    // in-band status with a glitch sample
    idle(4'hD, 4'hD, 1'b0, 1'b0);
    idle(4'hD, 4'hD, 1'b0, 1'b0);
    idle(4'hD, 4'hD, 1'b0, 1'b0);
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    idle(4'hD, 4'hD, 1'b0, 1'b0);
    idle(4'h3, 4'h3, 1'b0, 1'b0);
    idle(4'h5, 4'h3, 1'b0, 1'b0);
    idle(4'h3, 4'h3, 1'b0, 1'b0);

    // reset during the high nibble, released mid-frame
    nibs100(36'h0_0000_0555, 3);
    tick();
    rgmii_rxd_r = 4'h6; rgmii_ctl_r = 1'b1; rgmii_ctl_f = 1'b1;
    reset_n = 1'b0;
    expq.delete();
    m_mode = 1'b0; m_pn = 4'h0; m_pe = 1'b0; m_hunt = 1'b1; m_odd = 1'b0; m_stat = 4'h0;
    hist.delete();
    repeat (2) begin
      tick();
      rgmii_rxd_r = 4'($urandom);
    end
    nibs100(36'h1_2345_5D67, 9);
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    idle(4'h0, 4'h0, 1'b0, 1'b0);

    // randomized frames, gaps, speed changes and status codes
    for (int it = 0; it < 60; it++) begin
      tsp = 1'($urandom);
      for (int j = 0; j < $urandom_range(1, 5); j++) begin
        case ($urandom_range(0, 5))
          0:       r = 4'hD;
          1:       r = 4'hB;
          2:       r = 4'h0;
          3:       r = 4'h5;
          default: r = 4'($urandom);
        endcase
        f = ($urandom_range(0, 4) == 0) ? 4'($urandom) : r;
        idle(r, f, ($urandom_range(0, 9) == 0), tsp);
      end
      clear_fr();
      if (m_mode) begin
        len = $urandom_range(1, 10);
        for (int j = 0; j < len; j++) add_nib(4'($urandom), 4'($urandom), ($urandom_range(0, 14) == 0));
      end else begin
        len = $urandom_range(0, 7);
        for (int j = 0; j < len; j++) add_nib(4'h5, 4'($urandom), 1'b0);
        if ($urandom_range(0, 9) != 0) add_nib(4'hD, 4'($urandom), 1'b0);
        len = $urandom_range(0, 9);
        for (int j = 0; j < len; j++) add_nib(4'($urandom), 4'($urandom), ($urandom_range(0, 14) == 0));
        if (fr_n.size() == 0) add_nib(4'($urandom), 4'($urandom), 1'b0);
      end
      frame();
    end
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    idle(4'h0, 4'h0, 1'b0, 1'b0);
    drain_req = 1'b1;
  end

endmodule

// File: doc/rgmii_rx_assembler.md
Name: rgmii_rx_assembler

Overview:
- Receive-side counterpart of the RGMII transmit path. Takes RGMII receive data already split into rising-edge and falling-edge halves by the I/O capture stage (IDDR, same-edge-pipelined, outside this block) and rebuilds a GMII-style byte stream.
- At 1000M it merges nibble pairs every cycle. At 10/100M it assembles bytes from successive SDR nibbles and aligns them on the SFD.
- Also decodes RGMII in-band link status during inter-frame gaps.
- Sits between the I/O capture primitives and the MAC receive logic.

Parameters:
- STATUS_FILTER, 2: number of consecutive identical idle status samples required before the link_up/link_speed/full_duplex outputs update (legal range 1..15).

Ports:
- rxclk  input  1  receive clock from the PHY domain (125M/25M/2.5M); the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- speed  input  1  0 = 10/100M nibble mode, 1 = 1000M DDR mode.
- rgmii_rxd_r  input  4  data captured on the rxclk rising edge.
- rgmii_rxd_f  input  4  data captured on the rxclk falling edge.
- rgmii_ctl_r  input  1  RX_CTL captured on the rising edge (RX_DV).
- rgmii_ctl_f  input  1  RX_CTL captured on the falling edge (RX_DV xor RX_ER).
- rxd  output  8  assembled byte.
- rxdv  output  1  data valid, qualified by rxce.
- rxer  output  1  receive error / carrier-extend indication, qualified by rxce.
- rxce  output  1  byte strobe; rxd/rxdv/rxer are meaningful only when rxce=1.
- link_up  output  1  in-band link status.
- link_speed  output  2  in-band speed: 00=10M, 01=100M, 10=1000M, 11=reserved.
- full_duplex  output  1  in-band duplex.
- nibble_err  output  1  one-cycle pulse when a 10/100 frame ends on an odd nibble.

Behaviour:
- Decode: dv = rgmii_ctl_r; er = rgmii_ctl_r ^ rgmii_ctl_f.
- All outputs are registered.
- Reset values: rxd=0x00, rxdv=0, rxer=0, rxce=0, link_up=0, link_speed=00, full_duplex=0, nibble_err=0.
- Reset clears internal state: FSM goes to LO, sfd_seen=0, held nibble=0, filter counter=0.
- Reset asserted mid-frame aborts the frame. No partial byte is emitted after reset release.
- Speed mode register: speed is sampled into the active mode only on cycles where dv=0. A speed change while dv=1 takes effect at the first cycle with dv=0.
- 1000M mode:
  - Every cycle: rxd={rgmii_rxd_f,rgmii_rxd_r}, rxdv=dv, rxer=er, rxce=1.
  - Latency is 1 cycle.
- 10/100M, dv=0:
  - Every cycle: rxce=1, rxdv=0, rxer=er, rxd={rgmii_rxd_r,rgmii_rxd_r}.
  - FSM forced to LO, sfd_seen cleared.
  - This preserves false-carrier (0xE) and carrier-extend (0xF) codes.
- 10/100M, dv=1, FSM states:
  - LO: hold nibble n=rgmii_rxd_r and err e=er; rxce=0; go HI.
  - LO realign case: sfd_seen=0, current nibble=0xD and previous-cycle nibble=0x5. Emit rxd=0xD5, rxdv=1, rxer=er|prev_er, rxce=1; set sfd_seen; stay LO.
  - HI: emit rxd={rgmii_rxd_r,n}, rxdv=1, rxer=e|er, rxce=1; go LO. If the emitted byte is 0xD5, set sfd_seen.
  - After sfd_seen=1, no further realignment occurs in that frame.
  - Latency: a byte appears 1 cycle after the cycle carrying its high nibble (or the 0xD nibble in the realign case).
- Frame end in 10/100 (dv falls):
  - FSM in HI (odd nibble count): discard the held nibble and pulse nibble_err for 1 cycle, coincident with the first dv=0 output.
  - FSM in LO: no nibble_err.
- In-band status:
  - Candidate cycle: dv=0, er=0, and rgmii_rxd_r==rgmii_rxd_f.
  - Candidate = {full_duplex=r[3], link_speed=r[2:1], link_up=r[0]}.
  - The filter counter increments while the candidate equals the previous candidate. It resets to 1 on a different candidate and to 0 on any non-candidate cycle.
  - Outputs update when the counter reaches STATUS_FILTER. Updates are evaluated in both modes.
- Simultaneous events: a dv rising edge in the same cycle as a status update is not possible (status needs dv=0). A speed change and dv falling in the same cycle: the new speed governs the next cycle.

Test Plan:
- 1000M: drive r=0x5,f=0x5 ×7 then r=0x5,f=0xD, dv=1 → rxce=1 every cycle; seven 0x55 then 0xD5 with rxdv=1, each 1 cycle later.
- 10/100 aligned: dv=1 nibbles 5,5,5,5,5,D,1,2 → bytes 0x55,0x55,0xD5,0x21 with rxce on alternate cycles; nibble_err=0 at end.
- 10/100 misaligned: dv=1 nibbles 5,5,5,D,A,B → bytes 0x55, then 0xD5 the cycle after the D nibble, then 0xBA; rxer=0.
- 10/100 odd end: after the SFD, nibbles 3,4,7 then dv=0 → byte 0x43 emitted, nibble 7 dropped, nibble_err pulses exactly once.
- Status: idle with r=f=0xD for 1 cycle, then 0xD for 2 more cycles (STATUS_FILTER=2) → link_up=1, link_speed=10, full_duplex=1 after the 2nd identical sample; a single glitch sample 0x0 leaves the outputs unchanged.
- Reset mid-frame: assert reset_n=0 during 10/100 HI → all outputs zero immediately; after release with dv=1 mid-frame, no byte until a new SFD is aligned.
